// File: rtl/mileage_seg_scan_if.sv
// Display bus between the mileage stage / board and the 7-segment scan driver.
// The master drives mileage and display enable; the slave (scan driver) drives the pins.
interface mileage_seg_scan_if;
   logic [15:0] mile;
   logic        display_en;
   logic [3:0]  seg_en;
   logic [7:0]  seg_out;

   modport master (
      output mile,
      output display_en,
      input  seg_en,
      input  seg_out
   );

   modport slave (
      input  mile,
      input  display_en,
      output seg_en,
      output seg_out
   );
endinterface

// File: rtl/mileage_seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver for a 16-bit BCD odometer value.
// Optional leading-zero blanking: define SEG_ZERO_BLANK_EN.
module mileage_seg_scan #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic           clk,
   input  logic           reset_n,
   mileage_seg_scan_if.slave bus
);

   localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

   logic [CntW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     snap_q, snap_d;
   logic [3:0]      seg_en_q, seg_en_d;
   logic [7:0]      seg_out_q, seg_out_d;

   logic        tick;
   logic [1:0]  idx_next;
   logic [3:0]  nibble;
   logic        blank;

   function automatic logic [7:0] dec(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'hFC;
         4'd1:    s = 8'h60;
         4'd2:    s = 8'hDA;
         4'd3:    s = 8'hF2;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'hB6;
         4'd6:    s = 8'hBE;
         4'd7:    s = 8'hE0;
         4'd8:    s = 8'hFE;
         4'd9:    s = 8'hF6;
         default: s = 8'h9E;
      endcase
      return s;
   endfunction

   always_comb begin
      tick      = (div_cnt_q == CntLast);
      idx_next  = idx_q + 2'd1;
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      idx_d     = tick ? idx_next : idx_q;
      // Digit 0 starts a frame and decodes straight from the fresh sample.
      snap_d    = (tick && idx_next == 2'd0) ? bus.mile : snap_q;
      nibble    = snap_d[{idx_next, 2'b00} +: 4];

`ifdef SEG_ZERO_BLANK_EN
      unique case (idx_next)
         2'd0:    blank = 1'b0;
         2'd1:    blank = (snap_d[15:4] == 12'h000);
         2'd2:    blank = (snap_d[15:8] == 8'h00);
         default: blank = (snap_d[15:12] == 4'h0);
      endcase
`else
      blank = 1'b0;
`endif

      seg_en_d  = seg_en_q;
      seg_out_d = seg_out_q;
      // Disable overrides a coincident tick; the scan itself keeps advancing.
      if (!bus.display_en) begin
         seg_en_d  = 4'b0000;
         seg_out_d = 8'h00;
      end else if (tick) begin
         seg_en_d  = 4'b0001 << idx_next;
         seg_out_d = blank ? 8'h00 : dec(nibble);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
         idx_q     <= 2'd3;
         snap_q    <= 16'h0000;
         seg_en_q  <= 4'b0000;
         seg_out_q <= 8'h00;
      end else begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         seg_en_q  <= seg_en_d;
         seg_out_q <= seg_out_d;
      end
   end

   assign bus.seg_en  = seg_en_q;
   assign bus.seg_out = seg_out_q;

endmodule
